// File: rtl/hex_probe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hex_probe_pkg
// Purpose  : Shared seven-segment glyph table and helpers for hex_probe_mux.
// Revision : 1.0 - initial release
// ============================================================================
package hex_probe_pkg;

    localparam int         DP_BIT    = 7;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low {dp,g,f,e,d,c,b,a}; DP off in every entry. Entry 15 first.
    localparam logic [15:0][7:0] c_SEG_GLYPHS = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
        return c_SEG_GLYPHS[nib];
    endfunction

endpackage
`default_nettype wire

// File: rtl/hex_probe_mux_key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Purpose  : 2-FF synchroniser, stable-count debouncer and one-cycle press
//            pulse for a raw active-low key.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce #(
    parameter int DEB_CYC = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int                 c_CNT_W   = $clog2(DEB_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYC);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic               r_press;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_press  <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_MAX) begin
                // Input has disagreed for DEB_CYC cycles: accept it. Only the
                // falling (press) direction produces a pulse.
                r_stable <= r_sync2;
                r_cnt    <= '0;
                r_press  <= ~r_sync2;
            end else begin
                r_cnt <= r_cnt + c_CNT_ONE;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/hex_probe_mux.sv
`default_nettype none
// ============================================================================
// Module   : hex_probe_mux
// Purpose  : Selects one of NCH probe buses and shows it in hex on HEX
//            digits, with key-driven channel select and snapshot freeze.
//            Optional auto-scroll built when HEX_PROBE_AUTOSCROLL_EN defined.
// Revision : 1.0 - initial release
// ============================================================================
module hex_probe_mux
    import hex_probe_pkg::*;
#(
    parameter int NCH        = 6,
    parameter int W          = 16,
    parameter int NDIG       = 6,
    parameter int DEB_CYC    = 500000,
    parameter int SCROLL_CYC = 50000000
) (
    input  logic                    CLK1_50,
    input  logic                    RST,
    input  logic [NCH*W-1:0]        probe_in,
    input  logic                    key_next_n,
    input  logic                    key_frz_n,
    input  logic                    auto_en,
    output logic [NDIG*8-1:0]       HEX,
    output logic [$clog2(NCH)-1:0]  sel,
    output logic                    frozen
);

    localparam int                 c_SEL_W    = $clog2(NCH);
    localparam int                 c_NIB      = W / 4;
    localparam logic [c_SEL_W-1:0] c_SEL_LAST = c_SEL_W'(NCH - 1);
    localparam logic [c_SEL_W-1:0] c_SEL_ONE  = c_SEL_W'(1);

    logic                 w_next_press;
    logic                 w_frz_press;
    logic                 w_scroll_tick;
    logic [c_SEL_W-1:0]   r_sel;
    logic                 r_frozen;
    logic [NCH*W-1:0]     r_snap;
    logic [NDIG*8-1:0]    r_hex;
    logic [NCH*W-1:0]     w_src;
    logic [W-1:0]         w_val;
    logic [NDIG*8-1:0]    w_hex_next;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .clk     (CLK1_50),
        .rst     (RST),
        .i_key_n (key_next_n),
        .o_press (w_next_press)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_frz (
        .clk     (CLK1_50),
        .rst     (RST),
        .i_key_n (key_frz_n),
        .o_press (w_frz_press)
    );

`ifdef HEX_PROBE_AUTOSCROLL_EN
    localparam int                 c_SCR_W    = $clog2(SCROLL_CYC);
    localparam logic [c_SCR_W-1:0] c_SCR_LAST = c_SCR_W'(SCROLL_CYC - 1);
    localparam logic [c_SCR_W-1:0] c_SCR_ONE  = c_SCR_W'(1);

    logic [c_SCR_W-1:0] r_scroll_cnt;

    assign w_scroll_tick = auto_en && !r_frozen && (r_scroll_cnt == c_SCR_LAST);

    // A manual press restarts the dwell so the new channel gets a full period.
    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            r_scroll_cnt <= '0;
        end else if (!auto_en || r_frozen || w_next_press || w_scroll_tick) begin
            r_scroll_cnt <= '0;
        end else begin
            r_scroll_cnt <= r_scroll_cnt + c_SCR_ONE;
        end
    end
`else
    logic w_unused_auto_en;
    logic [31:0] w_unused_scroll_cyc;

    assign w_scroll_tick       = 1'b0;
    assign w_unused_auto_en    = auto_en;
    assign w_unused_scroll_cyc = SCROLL_CYC;
`endif

    always_ff @(posedge CLK1_50) begin
        if (RST) begin
            r_sel    <= '0;
            r_frozen <= 1'b0;
            r_snap   <= '0;
            r_hex    <= {NDIG{SEG_BLANK}};
        end else begin
            r_hex <= w_hex_next;
            // Press and tick in the same cycle advance by one, not two.
            if (w_next_press || w_scroll_tick) begin
                r_sel <= (r_sel == c_SEL_LAST) ? '0 : r_sel + c_SEL_ONE;
            end
            if (w_frz_press) begin
                if (!r_frozen) begin
                    r_snap   <= probe_in;
                    r_frozen <= 1'b1;
                end else begin
                    r_frozen <= 1'b0;
                end
            end
        end
    end

    assign w_src = r_frozen ? r_snap : probe_in;

    always_comb begin
        w_val = '0;
        for (int c = 0; c < NCH; c++) begin
            if (r_sel == c_SEL_W'(c)) begin
                w_val = w_src[c*W +: W];
            end
        end
    end

    always_comb begin
        w_hex_next = {NDIG{SEG_BLANK}};
        for (int d = 0; d < c_NIB; d++) begin
            w_hex_next[d*8 +: 8] = nibble_to_seg(w_val[d*4 +: 4]);
        end
        w_hex_next[(NDIG-1)*8 +: 8] = nibble_to_seg(4'(r_sel));
        w_hex_next[DP_BIT]          = ~r_frozen;
    end

    assign HEX    = r_hex;
    assign sel    = r_sel;
    assign frozen = r_frozen;

endmodule
`default_nettype wire
